// File: rtl/ia_frame_ctrl.sv
// Frames a UART byte stream into indexed register writes; IA_FRAME_CHECKSUM_EN adds a trailing mod-256 checksum byte.
// Latency: rx_done_tick -> update_reg is 1 cycle; pc_ready follows the final write (or the checksum byte) by 1 cycle.
// Backpressure: none, because the UART cannot be stalled. Every tick is consumed, and a stalled frame aborts on timeout.
module ia_frame_ctrl #(
    parameter int         NUM_BYTES      = 54,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter int         IDX_W          = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_done_tick,
    output logic [IDX_W-1:0] idx,
    output logic [7:0]       wr_data,
    output logic             update_reg,
    output logic             pc_ready,
    output logic             busy,
    output logic             frame_err
);

    localparam int               TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
`ifdef IA_FRAME_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             update_reg_q, update_reg_d;
    logic             pc_ready_q, pc_ready_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
`ifdef IA_FRAME_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        timer_d      = timer_q;
        idx_d        = '1;
        wr_data_d    = wr_data_q;
        update_reg_d = 1'b0;
        pc_ready_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef IA_FRAME_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            // DONE behaves like IDLE for the incoming byte so back-to-back frames lose nothing
            S_IDLE, S_DONE: begin
                pc_ready_d = (state_q == S_DONE);
                state_d    = S_IDLE;
                if (rx_done_tick && rx_data == SYNC_BYTE) begin
                    state_d    = S_RECV;
                    byte_cnt_d = '0;
                    timer_d    = '0;
`ifdef IA_FRAME_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end
            end
            S_RECV: begin
                if (rx_done_tick) begin
                    update_reg_d = 1'b1;
                    idx_d        = byte_cnt_q;
                    wr_data_d    = rx_data;
                    byte_cnt_d   = byte_cnt_q + 1'b1;
                    timer_d      = '0;
`ifdef IA_FRAME_CHECKSUM_EN
                    sum_d        = sum_q + rx_data;
                    if (byte_cnt_q == LAST_IDX) state_d = S_CHK;
`else
                    if (byte_cnt_q == LAST_IDX) state_d = S_DONE;
`endif
                end else if (timer_q == TMR_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                    byte_cnt_d  = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef IA_FRAME_CHECKSUM_EN
            S_CHK: begin
                if (rx_done_tick) begin
                    pc_ready_d  = (rx_data == sum_q);
                    frame_err_d = (rx_data != sum_q);
                    state_d     = S_IDLE;
                    byte_cnt_d  = '0;
                end else if (timer_q == TMR_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                    byte_cnt_d  = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            idx_q        <= '1;
            wr_data_q    <= 8'h00;
            update_reg_q <= 1'b0;
            pc_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef IA_FRAME_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            wr_data_q    <= wr_data_d;
            update_reg_q <= update_reg_d;
            pc_ready_q   <= pc_ready_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
`ifdef IA_FRAME_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign idx        = idx_q;
    assign wr_data    = wr_data_q;
    assign update_reg = update_reg_q;
    assign pc_ready   = pc_ready_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ia_frame_ctrl.sv
// Bench for ia_frame_ctrl: directed vector table, frame-level sequences and random streams against a byte-event model.
module tb_ia_frame_ctrl;

    localparam int         NB   = 54;
    localparam int         TO   = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [5:0] idx;
    logic [7:0] wr_data;
    logic       update_reg, pc_ready, busy, frame_err;

    ia_frame_ctrl #(
        .NUM_BYTES(NB), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO), .IDX_W(6)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .idx(idx), .wr_data(wr_data), .update_reg(update_reg), .pc_ready(pc_ready),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_upd = 0, n_pc = 0, n_err = 0;

    // Reference: frame-in-progress flag, payload count, and cycle stamp of the last accepted byte
    longint     cyc = 0;
    longint     m_last = 0;
    bit         m_active = 0, m_chk = 0, pend_pc = 0;
    int         m_got = 0;
    logic [7:0] m_sum = 8'h00;
    logic       e_upd = 0, e_pc = 0, e_err = 0, e_busy = 0;
    logic [5:0] e_idx = 6'h3F;
    logic [7:0] e_wr = 8'h00;

    function automatic void model_step(input logic r, input logic t, input logic [7:0] d);
        cyc++;
        e_upd = 1'b0; e_pc = 1'b0; e_err = 1'b0; e_idx = 6'h3F;
        if (r) begin
            m_active = 0; m_chk = 0; m_got = 0; pend_pc = 0;
            e_wr = 8'h00; e_busy = 1'b0;
            return;
        end
        e_pc = pend_pc;
        pend_pc = 0;
        if (m_active) begin
            if (t) begin
                if (m_chk) begin
                    if (d == m_sum) e_pc = 1'b1; else e_err = 1'b1;
                    m_active = 0;
                end else begin
                    e_upd = 1'b1; e_idx = 6'(m_got); e_wr = d;
                    m_sum = 8'(m_sum + d);
                    m_got++;
                    m_last = cyc;
                    if (m_got == NB) begin
`ifdef IA_FRAME_CHECKSUM_EN
                        m_chk = 1;
`else
                        m_active = 0;
                        pend_pc = 1;
`endif
                    end
                end
            end else if (cyc - m_last >= TO) begin
                e_err = 1'b1;
                m_active = 0;
            end
        end else if (t && d == SYNC) begin
            m_active = 1; m_chk = 0; m_got = 0; m_sum = 8'h00; m_last = cyc;
        end
        e_busy = m_active || pend_pc;
    endfunction

    task automatic drive(input logic r, input logic t, input logic [7:0] d);
        reset = r; rx_done_tick = t; rx_data = d;
        @(posedge clk);
        model_step(r, t, d);
        #1;
        if (update_reg === 1'b1) n_upd++;
        if (pc_ready === 1'b1) n_pc++;
        if (frame_err === 1'b1) n_err++;
    endtask

    task automatic check(input string name, input logic xu, input logic xp, input logic xe,
                         input logic xb, input logic [5:0] xi, input logic [7:0] xw);
        checks++;
        if ({update_reg, pc_ready, frame_err, busy, idx, wr_data} !== {xu, xp, xe, xb, xi, xw}) begin
            failures++;
            $display("FAIL %s t=%0t got upd=%b pc=%b err=%b busy=%b idx=%h wr=%h exp upd=%b pc=%b err=%b busy=%b idx=%h wr=%h",
                     name, $time, update_reg, pc_ready, frame_err, busy, idx, wr_data, xu, xp, xe, xb, xi, xw);
        end
    endtask

    task automatic cmp_model(input string name);
        check(name, e_upd, e_pc, e_err, e_busy, e_idx, e_wr);
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
            cmp_model("idle");
        end
        drive(1'b0, 1'b1, d);
        cmp_model("byte");
    endtask

    // Sync, payload 0..NB-1 back to back, plus the checksum byte when that build option is on
    task automatic send_frame();
        logic [7:0] s;
        s = 8'h00;
        send_byte(SYNC, 0);
        for (int i = 0; i < NB; i++) begin
            send_byte(8'(i), 0);
            s = 8'(s + 8'(i));
        end
`ifdef IA_FRAME_CHECKSUM_EN
        send_byte(s, 0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'h00);
            cmp_model("idle");
        end
    endtask

    typedef struct {
        logic       r;
        logic       t;
        logic [7:0] d;
        logic       upd;
        logic [5:0] xidx;
        logic [7:0] wr;
        logic       pc;
        logic       err;
        logic       bsy;
    } vec_t;

    vec_t tbl[12];
    int   u0, p0, f0, ng, gap, rr;

    initial begin
        reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'h77, 1'b1, 6'h00, 8'h77, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 6'h3F, 8'h77, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 6'h01, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'h10, 1'b1, 6'h02, 8'h10, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'h20, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h30, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'hA5, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'h44, 1'b1, 6'h00, 8'h44, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].t, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].upd, tbl[i].pc, tbl[i].err, tbl[i].bsy, tbl[i].xidx, tbl[i].wr);
        end
        drive(1'b1, 1'b0, 8'h00);
        check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 8'h00);

        // Full frame
        u0 = n_upd; p0 = n_pc; f0 = n_err;
        send_frame();
        idle(3);
        expect_int("full_strobes", n_upd - u0, NB);
        expect_int("full_pc", n_pc - p0, 1);
        expect_int("full_err", n_err - f0, 0);

        // Garbage before sync
        u0 = n_upd; p0 = n_pc;
        send_byte(8'h12, 0);
        send_byte(8'hFF, 1);
        expect_int("garbage_strobes", n_upd - u0, 0);
        send_frame();
        idle(2);
        expect_int("garbage_frame_strobes", n_upd - u0, NB);
        expect_int("garbage_frame_pc", n_pc - p0, 1);

        // Timeout after 10 bytes
        u0 = n_upd; p0 = n_pc; f0 = n_err;
        send_byte(SYNC, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i), 0);
        idle(TO + 2);
        expect_int("timeout_strobes", n_upd - u0, 10);
        expect_int("timeout_err", n_err - f0, 1);
        expect_int("timeout_pc", n_pc - p0, 0);
        expect_int("timeout_busy", int'(busy), 0);
        send_frame();
        idle(2);
        expect_int("after_timeout_pc", n_pc - p0, 1);

        // Gap boundary: TO-1 idle cycles still accepted, TO idle cycles abort
        u0 = n_upd; f0 = n_err;
        send_byte(SYNC, 0);
        send_byte(8'h11, TO - 1);
        send_byte(8'h22, TO - 1);
        expect_int("gap_edge_strobes", n_upd - u0, 2);
        idle(TO);
        expect_int("gap_edge_err", n_err - f0, 1);

        // Reset mid-frame
        p0 = n_pc; f0 = n_err;
        send_byte(SYNC, 0);
        for (int i = 0; i < 20; i++) send_byte(8'(i + 3), 0);
        drive(1'b1, 1'b0, 8'h00);
        check("midframe_reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 8'h00);
        idle(TO + 2);
        expect_int("midframe_reset_noerr", n_err - f0, 0);
        send_frame();
        idle(2);
        expect_int("midframe_reset_pc", n_pc - p0, 1);

        // Back-to-back frames: next sync during the pc_ready cycle, then during the DONE cycle
        p0 = n_pc; u0 = n_upd;
        send_frame();
        idle(1);
        send_frame();
        send_frame();
        idle(3);
        expect_int("b2b_pc", n_pc - p0, 3);
        expect_int("b2b_strobes", n_upd - u0, 3 * NB);

`ifdef IA_FRAME_CHECKSUM_EN
        p0 = n_pc; f0 = n_err;
        send_byte(SYNC, 0);
        for (int i = 0; i < NB; i++) send_byte(8'h01, 0);
        send_byte(8'h36, 0);
        idle(2);
        expect_int("chk_good_pc", n_pc - p0, 1);
        expect_int("chk_good_err", n_err - f0, 0);
        p0 = n_pc; f0 = n_err;
        send_byte(SYNC, 0);
        for (int i = 0; i < NB; i++) send_byte(8'h01, 0);
        send_byte(8'h35, 0);
        idle(2);
        expect_int("chk_bad_pc", n_pc - p0, 0);
        expect_int("chk_bad_err", n_err - f0, 1);
`endif

        // Random streams with garbage, boundary gaps and occasional resets
        for (int f = 0; f < 60; f++) begin
            ng = int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            send_byte(SYNC, int'($urandom_range(0, 2)));
            for (int i = 0; i < NB + 1; i++) begin
                gap = int'($urandom_range(0, 3));
                rr  = int'($urandom_range(0, 299));
                if (rr == 0) gap = TO;
                else if (rr == 1) gap = TO - 1;
                else if (rr == 2) begin
                    drive(1'b1, 1'b0, 8'h00);
                    cmp_model("rand_reset");
                end
                send_byte(8'($urandom_range(0, 255)), gap);
            end
        end
        idle(TO + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
